// File: rtl/i2s_chan_sched.sv
`default_nettype none
// ============================================================================
// Module   : i2s_chan_sched
// Stereo ADC -> shared engine -> DAC scheduler, round-robin L/R arbitration,
// overrun/underrun/timeout status. Define I2S_SCHED_CNT_EN for event counters.
// Revision : 1.0
// ============================================================================

module i2s_chan_sched #(
  parameter int W       = 24,
  parameter int TIMEOUT = 2048
) (
  input  logic         AMSCK,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] adc_data,
  input  logic         adc_valid_l,
  input  logic         adc_valid_r,
  input  logic         dac_rd_l,
  input  logic         dac_rd_r,
  output logic [W-1:0] dac_data,
  output logic         proc_start,
  output logic         proc_ch,
  output logic [W-1:0] proc_din,
  input  logic         proc_done,
  input  logic [W-1:0] proc_dout,
  input  logic         clr_status,
  output logic         ovr_l,
  output logic         ovr_r,
  output logic         unr_l,
  output logic         unr_r,
  output logic         tmo
`ifdef I2S_SCHED_CNT_EN
  ,
  output logic [15:0]  ovr_cnt,
  output logic [15:0]  unr_cnt,
  output logic [15:0]  tmo_cnt
`endif
);

  localparam int c_TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_TMR_W-1:0] r_timer;
  logic               r_last_ch;
  logic               r_hold;
  logic [W-1:0]       r_in_l;
  logic [W-1:0]       r_in_r;
  logic [W-1:0]       r_out_l;
  logic [W-1:0]       r_out_r;
  logic               r_pend_l;
  logic               r_pend_r;
  logic               r_fresh_l;
  logic               r_fresh_r;

  logic               w_dispatch;
  logic               w_sel_ch;
  logic               w_finish;
  logic               w_timeout;
  logic [W-1:0]       w_result;
  logic               w_disp_l;
  logic               w_disp_r;
  logic               w_res_l;
  logic               w_res_r;
  logic               w_byp_l;
  logic               w_byp_r;
  logic               w_rd_l;
  logic               w_rd_r;
  logic               w_ovr_l_set;
  logic               w_ovr_r_set;
  logic               w_unr_l_set;
  logic               w_unr_r_set;

  // ---------------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge AMSCK) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dispatch  = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    w_result    = proc_dout;
    // Tie goes to the channel that was not served last.
    if (r_pend_l && r_pend_r) begin
      w_sel_ch = ~r_last_ch;
    end else begin
      w_sel_ch = r_pend_r;
    end
    case (r_state)
      S_IDLE: begin
        if (enable && !r_hold && (r_pend_l || r_pend_r)) begin
          w_dispatch  = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (proc_done) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_timer == c_TMR_W'(TIMEOUT - 1)) begin
          w_finish    = 1'b1;
          w_timeout   = 1'b1;
          w_result    = proc_din;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign proc_start = (r_state == S_ISSUE);

  // r_hold keeps IDLE for one cycle after a job so the next issue lands no
  // earlier than three cycles after the completing strobe.
  always_ff @(posedge AMSCK) begin
    if (rst) begin
      r_timer   <= '0;
      r_last_ch <= 1'b1;
      r_hold    <= 1'b0;
      proc_ch   <= 1'b0;
      proc_din  <= '0;
    end else begin
      r_hold <= w_finish;
      if (w_dispatch) begin
        proc_ch  <= w_sel_ch;
        proc_din <= w_sel_ch ? r_in_r : r_in_l;
      end
      if (r_state == S_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT) begin
        r_timer <= r_timer + c_TMR_W'(1);
      end
      if (w_finish) begin
        r_last_ch <= proc_ch;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel capture, result store and DAC read
  // ---------------------------------------------------------------------------
  assign w_disp_l = w_dispatch && !w_sel_ch;
  assign w_disp_r = w_dispatch &&  w_sel_ch;
  assign w_res_l  = w_finish && !proc_ch;
  assign w_res_r  = w_finish &&  proc_ch;
  assign w_byp_l  = adc_valid_l && !enable;
  assign w_byp_r  = adc_valid_r && !enable;
  assign w_rd_l   = dac_rd_l;
  assign w_rd_r   = dac_rd_r && !dac_rd_l;

  // A sample being handed to the engine this cycle is not lost, so no overrun.
  assign w_ovr_l_set = adc_valid_l && r_pend_l && !w_disp_l;
  assign w_ovr_r_set = adc_valid_r && r_pend_r && !w_disp_r;
  assign w_unr_l_set = w_rd_l && !r_fresh_l;
  assign w_unr_r_set = w_rd_r && !r_fresh_r;

  always_ff @(posedge AMSCK) begin
    if (rst) begin
      r_in_l    <= '0;
      r_in_r    <= '0;
      r_pend_l  <= 1'b0;
      r_pend_r  <= 1'b0;
      r_out_l   <= '0;
      r_out_r   <= '0;
      r_fresh_l <= 1'b0;
      r_fresh_r <= 1'b0;
      dac_data  <= '0;
    end else begin
      if (adc_valid_l) begin
        r_in_l   <= adc_data;
        r_pend_l <= enable;
      end else if (w_disp_l) begin
        r_pend_l <= 1'b0;
      end
      if (adc_valid_r) begin
        r_in_r   <= adc_data;
        r_pend_r <= enable;
      end else if (w_disp_r) begin
        r_pend_r <= 1'b0;
      end

      if (w_byp_l) begin
        r_out_l <= adc_data;
      end else if (w_res_l) begin
        r_out_l <= w_result;
      end
      if (w_byp_r) begin
        r_out_r <= adc_data;
      end else if (w_res_r) begin
        r_out_r <= w_result;
      end

      if (w_byp_l || w_res_l) begin
        r_fresh_l <= 1'b1;
      end else if (w_rd_l) begin
        r_fresh_l <= 1'b0;
      end
      if (w_byp_r || w_res_r) begin
        r_fresh_r <= 1'b1;
      end else if (w_rd_r) begin
        r_fresh_r <= 1'b0;
      end

      if (w_rd_l) begin
        dac_data <= r_out_l;
      end else if (w_rd_r) begin
        dac_data <= r_out_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status; a set event in the clearing cycle wins
  // ---------------------------------------------------------------------------
  always_ff @(posedge AMSCK) begin
    if (rst) begin
      ovr_l <= 1'b0;
      ovr_r <= 1'b0;
      unr_l <= 1'b0;
      unr_r <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      ovr_l <= (ovr_l && !clr_status) || w_ovr_l_set;
      ovr_r <= (ovr_r && !clr_status) || w_ovr_r_set;
      unr_l <= (unr_l && !clr_status) || w_unr_l_set;
      unr_r <= (unr_r && !clr_status) || w_unr_r_set;
      tmo   <= (tmo   && !clr_status) || w_timeout;
    end
  end

`ifdef I2S_SCHED_CNT_EN
  function automatic logic [15:0] sat_add(input logic [15:0] base,
                                          input logic [1:0]  inc);
    logic [16:0] sum;
    sum = {1'b0, base} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [15:0] w_ovr_base;
  logic [15:0] w_unr_base;
  logic [15:0] w_tmo_base;

  assign w_ovr_base = clr_status ? 16'd0 : ovr_cnt;
  assign w_unr_base = clr_status ? 16'd0 : unr_cnt;
  assign w_tmo_base = clr_status ? 16'd0 : tmo_cnt;

  always_ff @(posedge AMSCK) begin
    if (rst) begin
      ovr_cnt <= '0;
      unr_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      ovr_cnt <= sat_add(w_ovr_base, {1'b0, w_ovr_l_set} + {1'b0, w_ovr_r_set});
      unr_cnt <= sat_add(w_unr_base, {1'b0, w_unr_l_set} + {1'b0, w_unr_r_set});
      tmo_cnt <= sat_add(w_tmo_base, {1'b0, w_timeout});
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2s_chan_sched.sv
`default_nettype none
// tb_i2s_chan_sched: directed vectors with hand-computed expectations for
// i2s_chan_sched (counter checks compiled in with I2S_SCHED_CNT_EN).

module tb_i2s_chan_sched;

  localparam int W       = 24;
  localparam int TIMEOUT = 2048;

  logic         AMSCK = 1'b0;
  logic         rst;
  logic         enable;
  logic [W-1:0] adc_data;
  logic         adc_valid_l;
  logic         adc_valid_r;
  logic         dac_rd_l;
  logic         dac_rd_r;
  logic [W-1:0] dac_data;
  logic         proc_start;
  logic         proc_ch;
  logic [W-1:0] proc_din;
  logic         proc_done;
  logic [W-1:0] proc_dout;
  logic         clr_status;
  logic         ovr_l;
  logic         ovr_r;
  logic         unr_l;
  logic         unr_r;
  logic         tmo;
`ifdef I2S_SCHED_CNT_EN
  logic [15:0]  ovr_cnt;
  logic [15:0]  unr_cnt;
  logic [15:0]  tmo_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 AMSCK = ~AMSCK;

  i2s_chan_sched #(.W(W), .TIMEOUT(TIMEOUT)) u_dut (
    .AMSCK       (AMSCK),
    .rst         (rst),
    .enable      (enable),
    .adc_data    (adc_data),
    .adc_valid_l (adc_valid_l),
    .adc_valid_r (adc_valid_r),
    .dac_rd_l    (dac_rd_l),
    .dac_rd_r    (dac_rd_r),
    .dac_data    (dac_data),
    .proc_start  (proc_start),
    .proc_ch     (proc_ch),
    .proc_din    (proc_din),
    .proc_done   (proc_done),
    .proc_dout   (proc_dout),
    .clr_status  (clr_status),
    .ovr_l       (ovr_l),
    .ovr_r       (ovr_r),
    .unr_l       (unr_l),
    .unr_r       (unr_r),
    .tmo         (tmo)
`ifdef I2S_SCHED_CNT_EN
    ,
    .ovr_cnt     (ovr_cnt),
    .unr_cnt     (unr_cnt),
    .tmo_cnt     (tmo_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge AMSCK);
    #1;
  endtask

  task automatic steps(input int n, output int starts);
    starts = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (proc_start) starts++;
    end
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (!proc_start && k < 64) begin
      step();
      k++;
    end
    check(tag, {31'd0, proc_start}, 32'd1);
  endtask

  task automatic adc_l(input logic [W-1:0] d);
    adc_data = d; adc_valid_l = 1'b1; step(); adc_valid_l = 1'b0;
  endtask

  task automatic adc_r(input logic [W-1:0] d);
    adc_data = d; adc_valid_r = 1'b1; step(); adc_valid_r = 1'b0;
  endtask

  task automatic rd_l();
    dac_rd_l = 1'b1; step(); dac_rd_l = 1'b0;
  endtask

  task automatic job_done(input logic [W-1:0] res);
    proc_dout = res; proc_done = 1'b1; step(); proc_done = 1'b0;
  endtask

  task automatic finish_job(input logic [W-1:0] res, input int busy);
    int s;
    steps(busy, s);
    job_done(res);
  endtask

  initial begin
    int s;
    rst = 1'b1; enable = 1'b1; adc_data = '0; adc_valid_l = 1'b0; adc_valid_r = 1'b0;
    dac_rd_l = 1'b0; dac_rd_r = 1'b0; proc_done = 1'b0; proc_dout = '0; clr_status = 1'b0;
    repeat (3) step();
    check("rst_dac_data", dac_data, 0);
    check("rst_start", proc_start, 0);
    check("rst_din", proc_din, 0);
    check("rst_ch", proc_ch, 0);
    check("rst_flags", {ovr_l, ovr_r, unr_l, unr_r, tmo}, 0);
    rst = 1'b0;
    step();

    // Left path: start two cycles after the strobe, result visible on read.
    adc_l(24'h123456);
    check("lat_t1_start", proc_start, 0);
    step();
    check("lat_t2_start", proc_start, 1);
    check("l_ch", proc_ch, 0);
    check("l_din", proc_din, 24'h123456);
    steps(10, s);
    check("l_busy_nostart", s, 0);
    job_done(24'h00ABCD);
    check("l_no_rd_yet", dac_data, 0);
    rd_l();
    check("l_dac", dac_data, 24'h00ABCD);
    check("l_flags", {ovr_l, ovr_r, unr_l, unr_r, tmo}, 0);

    // Tie: L then R a cycle later; R issues three cycles after L's done.
    adc_l(24'h000111);
    adc_r(24'h000222);
    check("tie_l_start", proc_start, 1);
    check("tie_l_ch", proc_ch, 0);
    check("tie_l_din", proc_din, 24'h000111);
    steps(20, s);
    check("tie_busy_nostart", s, 0);
    job_done(24'h0AAAAA);
    check("done_d1_start", proc_start, 0);
    step();
    check("done_d2_start", proc_start, 0);
    step();
    check("done_d3_start", proc_start, 1);
    check("tie_r_ch", proc_ch, 1);
    check("tie_r_din", proc_din, 24'h000222);
    step();
    adc_l(24'h000333);
    adc_r(24'h000444);
    check("inflight_no_ovr", {ovr_l, ovr_r}, 0);
    job_done(24'h0BBBBB);
    wait_start("both_pend_start");
    check("both_pend_ch", proc_ch, 0);
    check("both_pend_din", proc_din, 24'h000333);
    finish_job(24'h0CCCCC, 3);
    wait_start("both_pend_r_start");
    check("both_pend_r_din", proc_din, 24'h000444);
    finish_job(24'h0DDDDD, 2);

    // Overrun on R while L is in WAIT; newest R sample goes to the engine.
    adc_l(24'h000555);
    wait_start("ovr_l_start");
    step();
    adc_r(24'h000001);
    adc_r(24'h000002);
    check("ovr_r_set", ovr_r, 1);
    check("ovr_l_clear", ovr_l, 0);
    job_done(24'h0EEEEE);
    wait_start("ovr_r_start");
    check("ovr_r_ch", proc_ch, 1);
    check("ovr_r_din", proc_din, 24'h000002);
    finish_job(24'h0FFFFF, 2);

    // Timeout on R: raw sample bypassed to the output.
    adc_r(24'h7FFFFF);
    wait_start("tmo_start");
    check("tmo_din", proc_din, 24'h7FFFFF);
    step();
    repeat (TIMEOUT - 1) step();
    check("tmo_early", tmo, 0);
    step();
    check("tmo_set", tmo, 1);
    job_done(24'h111111);
    steps(4, s);
    check("late_done_nostart", s, 0);
    dac_rd_r = 1'b1; step(); dac_rd_r = 1'b0;
    check("tmo_dac", dac_data, 24'h7FFFFF);
    check("tmo_no_unr_r", unr_r, 0);

    // Underrun: second read repeats the last L result.
    rd_l();
    check("unr_rd1", dac_data, 24'h0EEEEE);
    check("unr_rd1_flag", unr_l, 0);
    rd_l();
    check("unr_rd2", dac_data, 24'h0EEEEE);
    check("unr_rd2_flag", unr_l, 1);
    dac_rd_l = 1'b1; dac_rd_r = 1'b1; step(); dac_rd_l = 1'b0; dac_rd_r = 1'b0;
    check("dual_rd_left", dac_data, 24'h0EEEEE);
    check("dual_rd_r_ignored", unr_r, 0);

    // Pass-through with the engine disabled.
    enable = 1'b0;
    adc_l(24'h0F0F0F);
    steps(3, s);
    check("byp_nostart", s, 0);
    rd_l();
    check("byp_dac", dac_data, 24'h0F0F0F);
    enable = 1'b1;
    steps(3, s);
    check("byp_no_pend", s, 0);

    // Clear, then reset in the middle of a job.
    clr_status = 1'b1; step(); clr_status = 1'b0;
    check("clr_flags", {ovr_l, ovr_r, unr_l, unr_r, tmo}, 0);
    adc_l(24'h000999);
    wait_start("rst_job_start");
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_start", proc_start, 0);
    check("midrst_din", proc_din, 0);
    check("midrst_dac", dac_data, 0);
    job_done(24'h123123);
    steps(3, s);
    check("midrst_done_ignored", s, 0);
    rd_l();
    check("midrst_out_l", dac_data, 0);
    check("midrst_unr_l", unr_l, 1);

    // Clear coinciding with an overrun: the flag survives.
    adc_l(24'h00000A);
    wait_start("clr_job_start");
    step();
    adc_r(24'h000001);
    clr_status = 1'b1;
    adc_r(24'h000002);
    clr_status = 1'b0;
    check("clr_ovr_wins", ovr_r, 1);
    check("clr_unr_cleared", unr_l, 0);
    adc_r(24'h000003);
    adc_r(24'h000004);
`ifdef I2S_SCHED_CNT_EN
    check("ovr_cnt3", ovr_cnt, 3);
`endif
    job_done(24'h000000);
    wait_start("clr_r_start");
    check("clr_r_din", proc_din, 24'h000004);
    finish_job(24'h000000, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2s_chan_sched.md
Name: i2s_chan_sched

Overview:
Sequences stereo audio samples between the I2S interface and a single shared processing engine (FIR/MAC). ADC samples tagged left/right are captured and dispatched one at a time to the engine, with round-robin arbitration between channels. Results are held per channel and presented on the DAC data input when the I2S block requests a sample. The block also detects overrun, underrun and engine timeout.

Parameters:
W, 24, sample width (ADC, DAC and engine data)
TIMEOUT, 2048, max cycles in WAIT before abort (one 48 kHz frame at 98.304 MHz)

Ports:
AMSCK  in  1  system clock, 98.304 MHz
rst  in  1  reset, synchronous, active-high
enable  in  1  1 = route through engine; 0 = pass-through
adc_data  in  W  ADC sample, valid with adc_valid_l/r
adc_valid_l  in  1  one-cycle strobe, left sample on adc_data
adc_valid_r  in  1  one-cycle strobe, right sample on adc_data
dac_rd_l  in  1  one-cycle request for left DAC sample
dac_rd_r  in  1  one-cycle request for right DAC sample
dac_data  out  W  DAC sample to I2S, registered
proc_start  out  1  one-cycle engine start pulse
proc_ch  out  1  channel of current job (0 = L, 1 = R)
proc_din  out  W  engine input sample, stable from start until done/abort
proc_done  in  1  engine completion strobe
proc_dout  in  W  engine result, valid with proc_done
clr_status  in  1  clears sticky flags
ovr_l, ovr_r  out  1  sticky overrun flags
unr_l, unr_r  out  1  sticky underrun flags
tmo  out  1  sticky engine-timeout flag

Behaviour:
- Reset: all outputs 0; in_l/in_r/out_l/out_r = 0; pend and fresh = 0; FSM = IDLE; last_ch = 1, so left wins the first tie.
- Capture on adc_valid_x at edge t:
  - in_x <= adc_data and pend_x <= 1 at t+1.
  - If pend_x was already 1, set ovr_x; the new sample overwrites the old one.
  - A channel whose job is in flight is not pending, so a new sample for it is not an overrun.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE, enable=1, any pend:
    - Choose ch: the only pending channel, or on a tie the channel != last_ch.
    - Latch proc_din <= in_ch and proc_ch <= ch; clear pend_ch.
    - If adc_valid for ch occurs in the same cycle, pend_ch stays 1 (set wins) and in_ch takes the new sample; proc_din keeps the old one.
    - Go to ISSUE.
  - ISSUE: proc_start = 1 for exactly this cycle; timer <= 0; go to WAIT.
  - WAIT, proc_done = 1: out_ch <= proc_dout; fresh_ch <= 1; last_ch <= ch; go to IDLE.
  - WAIT, timer == TIMEOUT-1 without done: set tmo; out_ch <= proc_din (raw bypass); fresh_ch <= 1; last_ch <= ch; go to IDLE.
  - proc_done outside WAIT is ignored.
- Latency:
  - adc_valid at t gives proc_start high in cycle t+2.
  - proc_done at d updates out_ch at d+1; the next proc_start is at d+3 at the earliest.
- enable=0:
  - The FSM does not leave IDLE.
  - adc_valid_x also writes out_x <= adc_data and fresh_x <= 1 directly, and clears pend_x.
  - A job already in ISSUE/WAIT completes normally.
- DAC:
  - dac_rd_x at t gives dac_data <= out_x at t+1, well inside the 5-cycle stability window.
  - fresh_x <= 0 on rd; if fresh_x was 0, set unr_x and repeat the previous out_x.
  - Result write and rd on the same channel in the same cycle: dac_data gets the old out_x; fresh_x ends at 1.
  - dac_rd_l and dac_rd_r together: left served, right ignored.
- clr_status clears all sticky flags; a same-cycle set event wins.
- Reset mid-job: the FSM returns to IDLE and any later proc_done is ignored.

Optional Feature:
- Macro: I2S_SCHED_CNT_EN.
- When defined, adds outputs ovr_cnt, unr_cnt and tmo_cnt (16 bits each).
  - Each counter increments on every event that sets the corresponding sticky flag (L and R summed).
  - Counters saturate at 0xFFFF, clear on rst or clr_status, and are 0 after reset.
- When not defined, these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Left path: adc_valid_l with 0x123456; engine returns 0x00ABCD after 10 cycles -> proc_start at t+2 with proc_ch=0, proc_din=0x123456; dac_rd_l afterwards -> dac_data=0x00ABCD one cycle later; no flags set.
- Tie: adc_valid_l, then adc_valid_r one cycle later, engine busy 20 cycles -> L issued first, R issued after L done; then valid L+R pending together with last_ch=1 -> L chosen.
- Overrun: two adc_valid_r (0x000001, 0x000002) while a left job is in WAIT -> ovr_r=1; R job issued with proc_din=0x000002.
- Timeout: engine never asserts done, sample 0x7FFFFF on R -> tmo=1 at WAIT+2048 cycles; dac_rd_r -> 0x7FFFFF; late proc_done ignored.
- Underrun and bypass: dac_rd_l twice with no new result -> second read repeats the value, unr_l=1; with enable=0, adc_valid_l 0x0F0F0F then dac_rd_l -> 0x0F0F0F, no proc_start.
- Reset/clear: rst asserted in WAIT -> all outputs 0, next proc_done ignored; clr_status coinciding with an overrun event -> ovr flag remains 1. With I2S_SCHED_CNT_EN, 3 overruns -> ovr_cnt=3.
